// File: rtl/ii_window_writer.sv
// Writes one zero-padded integral-image window into the cascade II RAM, then starts the cascade and relays its verdict.
// Define IIW_VARIANCE_EN to add the sum/sqsum accumulators and the isqrt of the variance normalisation factor.
module ii_window_writer #(
    parameter int LENGHT_LINE_II = 21,
    parameter int ADDR_WIDTH_II  = $clog2(LENGHT_LINE_II*LENGHT_LINE_II)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     win_start_i,
    input  logic [7:0]               pix_data_i,
    input  logic                     pix_val_i,
    output logic                     pix_ready_o,
    output logic [ADDR_WIDTH_II-1:0] ii_addr_wr_o,
    output logic [31:0]              ii_data_wr_o,
    output logic                     ii_val_wr_o,
    output logic [31:0]              variance_norm_factor_o,
    output logic                     start_o,
    input  logic                     done_i,
    input  logic                     result_i,
    output logic                     busy_o,
    output logic                     result_o,
    output logic                     result_val_o
);

    localparam int L    = LENGHT_LINE_II;
    localparam int W    = LENGHT_LINE_II - 1;
    localparam int CW   = $clog2(L);
    localparam int CLRW = $clog2(2*L);

    localparam logic [CW-1:0]            X_LAST      = CW'(W-1);
    localparam logic [CLRW-1:0]          CLR_LAST    = CLRW'(2*L-2);
    localparam logic [CLRW-1:0]          CLR_ROW_END = CLRW'(L);
    localparam logic [ADDR_WIDTH_II-1:0] L_ADDR      = ADDR_WIDTH_II'(L);
    localparam logic [ADDR_WIDTH_II-1:0] ONE_ADDR    = ADDR_WIDTH_II'(1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CLEAR = 3'd1;
    localparam logic [2:0] LOAD  = 3'd2;
    localparam logic [2:0] START = 3'd3;
    localparam logic [2:0] WAIT  = 3'd4;
`ifdef IIW_VARIANCE_EN
    localparam logic [2:0] SQRT  = 3'd5;
`endif

    logic [2:0]               state;
    logic [CW-1:0]            x_cnt;
    logic [CW-1:0]            y_cnt;
    logic [CLRW-1:0]          clr_cnt;
    logic [ADDR_WIDTH_II-1:0] clr_addr;
    logic [ADDR_WIDTH_II-1:0] wr_base;
    logic [31:0]              rowacc;
    logic [31:0]              lbuf [W];

    logic [31:0] rowacc_nxt;
    logic [31:0] ii_nxt;
    logic        pix_acc;
    logic        last_pix;

    assign pix_acc  = pix_val_i & pix_ready_o;
    assign last_pix = (x_cnt == X_LAST) && (y_cnt == X_LAST);

    // Running row sum plus the column total above gives the II value for (y+1, x+1).
    always_comb begin
        rowacc_nxt = ((x_cnt == '0) ? 32'd0 : rowacc) + 32'(pix_data_i);
        ii_nxt     = rowacc_nxt + lbuf[x_cnt];
    end

`ifdef IIW_VARIANCE_EN
    logic [31:0] sum;
    logic [31:0] sqsum;
    logic [15:0] pix_sq;
    logic [5:0]  sq_idx;
    logic [21:0] rem;
    logic [19:0] root;
    logic [39:0] d_var;
    logic [23:0] rem_sh;
    logic [23:0] trial;
    logic [21:0] rem_nxt;
    logic [19:0] root_nxt;

    assign pix_sq = 16'(pix_data_i) * 16'(pix_data_i);

    // Restoring isqrt: consume d two bits at a time, MSB pair first, one root bit per cycle.
    always_comb begin
        // NOTE: every output of a combinational block gets a value on every path, so no latch is inferred.
        d_var    = 40'(sqsum) * 40'(W*W) - 40'(sum) * 40'(sum);
        rem_sh   = {rem, d_var[sq_idx +: 2]};
        trial    = {2'b00, root, 2'b01};
        rem_nxt  = rem_sh[21:0];
        root_nxt = {root[18:0], 1'b0};
        if (rem_sh >= trial) begin
            rem_nxt  = 22'(rem_sh - trial);
            root_nxt = {root[18:0], 1'b1};
        end
    end
`else
    assign variance_norm_factor_o = 32'd1;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state        <= IDLE;
            x_cnt        <= '0;
            y_cnt        <= '0;
            clr_cnt      <= '0;
            clr_addr     <= '0;
            wr_base      <= L_ADDR;
            rowacc       <= '0;
            pix_ready_o  <= 1'b0;
            ii_addr_wr_o <= '0;
            ii_data_wr_o <= '0;
            ii_val_wr_o  <= 1'b0;
            start_o      <= 1'b0;
            busy_o       <= 1'b0;
            result_o     <= 1'b0;
            result_val_o <= 1'b0;
            // NOTE: the line buffer is a small register file, so it is reset like any other state.
            for (int i = 0; i < W; i++) lbuf[i] <= '0;
`ifdef IIW_VARIANCE_EN
            sum                    <= '0;
            sqsum                  <= '0;
            sq_idx                 <= '0;
            rem                    <= '0;
            root                   <= '0;
            variance_norm_factor_o <= '0;
`endif
        end else begin
            ii_val_wr_o  <= 1'b0;
            start_o      <= 1'b0;
            result_val_o <= 1'b0;
            case (state)
                IDLE: begin
                    x_cnt   <= '0;
                    y_cnt   <= '0;
                    rowacc  <= '0;
                    wr_base <= L_ADDR;
                    for (int i = 0; i < W; i++) lbuf[i] <= '0;
`ifdef IIW_VARIANCE_EN
                    sum   <= '0;
                    sqsum <= '0;
`endif
                    if (win_start_i) begin
                        state        <= CLEAR;
                        busy_o       <= 1'b1;
                        ii_val_wr_o  <= 1'b1;
                        ii_addr_wr_o <= '0;
                        ii_data_wr_o <= '0;
                        clr_cnt      <= CLRW'(1);
                        clr_addr     <= ONE_ADDR;
`ifdef IIW_VARIANCE_EN
                        variance_norm_factor_o <= '0;
`endif
                    end
                end
                CLEAR: begin
                    // Row 0 runs straight into column 0 at address L, after which it strides by L.
                    ii_val_wr_o  <= 1'b1;
                    ii_addr_wr_o <= clr_addr;
                    ii_data_wr_o <= '0;
                    clr_cnt      <= clr_cnt + CLRW'(1);
                    clr_addr     <= (clr_cnt < CLR_ROW_END) ? clr_addr + ONE_ADDR : clr_addr + L_ADDR;
                    if (clr_cnt == CLR_LAST) begin
                        state       <= LOAD;
                        pix_ready_o <= 1'b1;
                    end
                end
                LOAD: begin
                    if (pix_acc) begin
                        rowacc       <= rowacc_nxt;
                        lbuf[x_cnt]  <= ii_nxt;
                        ii_val_wr_o  <= 1'b1;
                        ii_addr_wr_o <= wr_base + ADDR_WIDTH_II'(x_cnt) + ONE_ADDR;
                        ii_data_wr_o <= ii_nxt;
`ifdef IIW_VARIANCE_EN
                        sum   <= sum + 32'(pix_data_i);
                        sqsum <= sqsum + 32'(pix_sq);
`endif
                        if (x_cnt == X_LAST) begin
                            x_cnt   <= '0;
                            y_cnt   <= y_cnt + CW'(1);
                            wr_base <= wr_base + L_ADDR;
                        end else begin
                            x_cnt <= x_cnt + CW'(1);
                        end
                        if (last_pix) begin
                            pix_ready_o <= 1'b0;
`ifdef IIW_VARIANCE_EN
                            state  <= SQRT;
                            sq_idx <= 6'd38;
                            rem    <= '0;
                            root   <= '0;
`else
                            state <= START;
`endif
                        end
                    end
                end
`ifdef IIW_VARIANCE_EN
                SQRT: begin
                    rem    <= rem_nxt;
                    root   <= root_nxt;
                    sq_idx <= sq_idx - 6'd2;
                    if (sq_idx == 6'd0) begin
                        variance_norm_factor_o <= 32'(root_nxt);
                        state                  <= START;
                    end
                end
`endif
                START: begin
                    start_o <= 1'b1;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (done_i) begin
                        result_o     <= result_i;
                        result_val_o <= 1'b1;
                        busy_o       <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ii_window_writer.sv
// Scoreboard bench for ii_window_writer: driver pushes expected II writes, factors and verdicts; a negedge monitor pops and compares.
// Honours IIW_VARIANCE_EN for the expected factor and start latency.
module tb_ii_window_writer;

    localparam int L  = 21;
    localparam int W  = L - 1;
    localparam int AW = $clog2(L*L);

`ifdef IIW_VARIANCE_EN
    localparam int START_LAT = 22;
    localparam int FAC_RST   = 0;
`else
    localparam int START_LAT = 2;
    localparam int FAC_RST   = 1;
`endif

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          win_start_i = 1'b0;
    logic [7:0]    pix_data_i = '0;
    logic          pix_val_i = 1'b0;
    logic          pix_ready_o;
    logic [AW-1:0] ii_addr_wr_o;
    logic [31:0]   ii_data_wr_o;
    logic          ii_val_wr_o;
    logic [31:0]   variance_norm_factor_o;
    logic          start_o;
    logic          done_i = 1'b0;
    logic          result_i = 1'b0;
    logic          busy_o;
    logic          result_o;
    logic          result_val_o;

    ii_window_writer #(.LENGHT_LINE_II(L), .ADDR_WIDTH_II(AW)) dut (
        .clk_i                  (clk_i),
        .rst_i                  (rst_i),
        .win_start_i            (win_start_i),
        .pix_data_i             (pix_data_i),
        .pix_val_i              (pix_val_i),
        .pix_ready_o            (pix_ready_o),
        .ii_addr_wr_o           (ii_addr_wr_o),
        .ii_data_wr_o           (ii_data_wr_o),
        .ii_val_wr_o            (ii_val_wr_o),
        .variance_norm_factor_o (variance_norm_factor_o),
        .start_o                (start_o),
        .done_i                 (done_i),
        .result_i               (result_i),
        .busy_o                 (busy_o),
        .result_o               (result_o),
        .result_val_o           (result_val_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int     addr;
        longint data;
    } wr_t;

    wr_t    exp_wr[$];
    longint exp_fac[$];
    bit     exp_res[$];
    int     pix [W][W];
    int     n_tests = 0;
    int     n_fail  = 0;
    int     cyc = 0;
    int     last_acc_cyc = 0;

    always @(posedge clk_i) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Monitor: every DUT-presented output event is matched against the scoreboard queues.
    always @(negedge clk_i) begin
        wr_t w;
        if (pix_val_i && pix_ready_o) last_acc_cyc = cyc;
        if (ii_val_wr_o) begin
            if (exp_wr.size() == 0) fail_now("ii_write_unexpected");
            else begin
                w = exp_wr.pop_front();
                check("ii_addr", 64'(ii_addr_wr_o), 64'(w.addr));
                check("ii_data", 64'(ii_data_wr_o), 64'(w.data));
            end
        end
        if (start_o) begin
            if (exp_fac.size() == 0) fail_now("start_unexpected");
            else begin
                check("variance_factor", 64'(variance_norm_factor_o), 64'(exp_fac.pop_front()));
                check("start_latency", 64'(cyc - last_acc_cyc), 64'(START_LAT));
                check("busy_at_start", 64'(busy_o), 64'd1);
            end
        end
        if (result_val_o) begin
            if (exp_res.size() == 0) fail_now("result_strobe_unexpected");
            else begin
                check("result_o", 64'(result_o), 64'(exp_res.pop_front()));
                check("busy_at_result", 64'(busy_o), 64'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pix_ready"}, 64'(pix_ready_o), 64'd0);
        check({tag, "_ii_addr"}, 64'(ii_addr_wr_o), 64'd0);
        check({tag, "_ii_data"}, 64'(ii_data_wr_o), 64'd0);
        check({tag, "_ii_val"}, 64'(ii_val_wr_o), 64'd0);
        check({tag, "_factor"}, 64'(variance_norm_factor_o), 64'(FAC_RST));
        check({tag, "_start"}, 64'(start_o), 64'd0);
        check({tag, "_busy"}, 64'(busy_o), 64'd0);
        check({tag, "_result"}, 64'(result_o), 64'd0);
        check({tag, "_result_val"}, 64'(result_val_o), 64'd0);
    endtask

    function automatic void build(input int kind);
        for (int y = 0; y < W; y++)
            for (int x = 0; x < W; x++)
                case (kind)
                    0:       pix[y][x] = 1;
                    1:       pix[y][x] = ((x + y) % 2 == 1) ? 255 : 0;
                    default: pix[y][x] = int'($urandom_range(255));
                endcase
    endfunction

    // Integral image by direct summation of the rectangle above-left of each entry.
    function automatic void push_expected(input int n_pix);
        wr_t w;
        for (int j = 0; j < L; j++) begin
            w.addr = j; w.data = 0; exp_wr.push_back(w);
        end
        for (int r = 1; r < L; r++) begin
            w.addr = r * L; w.data = 0; exp_wr.push_back(w);
        end
        for (int i = 0; i < n_pix; i++) begin
            int y = i / W;
            int x = i % W;
            longint s = 0;
            for (int yy = 0; yy <= y; yy++)
                for (int xx = 0; xx <= x; xx++)
                    s += longint'(pix[yy][xx]);
            w.addr = (y + 1) * L + (x + 1);
            w.data = s;
            exp_wr.push_back(w);
        end
    endfunction

    function automatic longint model_factor();
`ifdef IIW_VARIANCE_EN
        longint s = 0, q = 0, d, r;
        for (int y = 0; y < W; y++)
            for (int x = 0; x < W; x++) begin
                s += longint'(pix[y][x]);
                q += longint'(pix[y][x] * pix[y][x]);
            end
        d = longint'(W * W) * q - s * s;
        r = longint'($sqrt(real'(d)));
        while (r * r > d) r--;
        while ((r + 1) * (r + 1) <= d) r++;
        return r;
`else
        return 1;
`endif
    endfunction

    task automatic run_window(input int kind, input bit gaps, input int abort_after, input bit res);
        int n;
        int t;
        build(kind);
        n = (abort_after > 0) ? abort_after : W * W;
        push_expected(n);
        if (abort_after == 0) exp_fac.push_back(model_factor());

        win_start_i = 1'b1;
        step();
        win_start_i = 1'b0;
        check("busy_after_win_start", 64'(busy_o), 64'd1);

        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                // Idle cycles also toggle done_i / win_start_i, which must be ignored here.
                repeat ($urandom_range(3)) begin
                    pix_val_i   = 1'b0;
                    done_i      = 1'($urandom_range(1));
                    win_start_i = 1'($urandom_range(1));
                    step();
                end
                done_i      = 1'b0;
                win_start_i = 1'b0;
            end
            pix_val_i  = 1'b1;
            pix_data_i = 8'(pix[i / W][i % W]);
            t = 0;
            while (!pix_ready_o && t < 200) begin
                step();
                t++;
            end
            if (t >= 200) begin
                fail_now("pix_ready_timeout");
                pix_val_i = 1'b0;
                return;
            end
            step();
        end
        pix_val_i = 1'b0;

        if (abort_after > 0) begin
            rst_i = 1'b1;
            step();
            rst_i = 1'b0;
            check_reset_outputs("abort");
            check("abort_writes_left", 64'(exp_wr.size()), 64'd0);
            exp_wr.delete();
            repeat (40) begin
                step();
                check("no_start_after_abort", 64'(start_o), 64'd0);
            end
            return;
        end

        t = 0;
        while (!start_o && t < 100) begin
            step();
            t++;
        end
        if (t >= 100) begin
            fail_now("start_timeout");
            return;
        end

        repeat ($urandom_range(4)) step();
        done_i   = 1'b1;
        result_i = res;
        exp_res.push_back(res);
        step();
        done_i   = 1'b0;
        result_i = 1'b0;
        check("result_val_after_done", 64'(result_val_o), 64'd1);
        step();
        check("result_val_one_cycle", 64'(result_val_o), 64'd0);
        check("idle_not_busy", 64'(busy_o), 64'd0);
    endtask

    initial begin
        repeat (3) step();
        rst_i = 1'b0;
        check_reset_outputs("reset");

        run_window(0, 1'b0, 0, 1'b1);
        // A done_i while idle must not produce a strobe.
        done_i   = 1'b1;
        result_i = 1'b1;
        step();
        done_i   = 1'b0;
        result_i = 1'b0;
        repeat (3) begin
            check("no_strobe_in_idle", 64'(result_val_o), 64'd0);
            step();
        end

        run_window(1, 1'b0, 0, 1'b0);
        run_window(1, 1'b1, 0, 1'b1);
        repeat (3) run_window(2, 1'b1, 0, 1'($urandom_range(1)));
        run_window(2, 1'b0, 150, 1'b0);
        run_window(0, 1'b0, 0, 1'b1);

        repeat (5) step();
        check("wr_queue_drained", 64'(exp_wr.size()), 64'd0);
        check("fac_queue_drained", 64'(exp_fac.size()), 64'd0);
        check("res_queue_drained", 64'(exp_res.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ii_window_writer.md
# ii_window_writer

Initiator side of the cascade evaluation interface. It accepts one detection window of 8-bit pixels in raster order and writes the zero-padded integral image into the cascade's II RAM. It computes the variance normalisation factor, pulses start, then waits for done and reports the window result upstream. It sits between the pixel/window scheduler and the cascade evaluator.

## Interface
Parameters:
- LENGHT_LINE_II, 21: II line length; the window is (LENGHT_LINE_II-1)² pixels.
- ADDR_WIDTH_II, $clog2(LENGHT_LINE_II*LENGHT_LINE_II): II RAM address width.

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  synchronous, active-high reset.
- win_start_i  in  1  begin a new window; honoured only in IDLE.
- pix_data_i  in  8  pixel value.
- pix_val_i  in  1  pixel valid.
- pix_ready_o  out  1  pixel accepted when pix_val_i & pix_ready_o.
- ii_addr_wr_o  out  ADDR_WIDTH_II  II RAM write address.
- ii_data_wr_o  out  32  II RAM write data.
- ii_val_wr_o  out  1  II RAM write enable.
- variance_norm_factor_o  out  32  isqrt(N·sqsum − sum²), zero-extended; stable from START until the next CLEAR.
- start_o  out  1  one-cycle start pulse to the cascade.
- done_i  in  1  cascade finished.
- result_i  in  1  cascade verdict, valid with done_i.
- busy_o  out  1  high in every state except IDLE.
- result_o  out  1  window verdict.
- result_val_o  out  1  one-cycle strobe qualifying result_o.

## Operation
- FSM: IDLE → CLEAR → LOAD → SQRT → START → WAIT → IDLE.
- **IDLE:**
  - On win_start_i, go to CLEAR.
  - Zero the line buffer, sum, sqsum, row and column counters.
- **CLEAR:**
  - Write 0 to row 0 at addresses 0..L−1, then to column 0 at addresses L, 2L, …, (L−1)·L.
  - One write per cycle, 2L−1 cycles in total (41 for L=21).
- **LOAD:**
  - pix_ready_o = 1.
  - Per accepted pixel p at (y,x), with W = L−1:
    - rowacc = (x==0 ? 0 : rowacc) + p.
    - ii = rowacc + lbuf[x]; lbuf[x] ← ii.
    - Write ii to address (y+1)·L + (x+1).
  - sum += p (32 bit); sqsum += p² (32 bit).
  - After pixel W·W is accepted, pix_ready_o drops in the same cycle as the final accept's registered output, and the FSM goes to SQRT.
- **SQRT:**
  - d = W·W·sqsum − sum², computed in 40-bit unsigned arithmetic; d ≥ 0 always.
  - Restoring integer square root, one result bit per cycle, 20 cycles.
  - Result is floor(sqrt(d)).
- **START:** assert start_o for one cycle, then go to WAIT.
- **WAIT:**
  - On done_i, register result_i into result_o.
  - Pulse result_val_o the next cycle, then return to IDLE.
- done_i outside WAIT is ignored. win_start_i outside IDLE is ignored.
- Reset mid-operation: FSM → IDLE; all counters and the line buffer cleared; no start_o or result_val_o is produced for the aborted window.

## Timing
- **Reset values:**
  - 0: pix_ready_o, ii_addr_wr_o, ii_data_wr_o, ii_val_wr_o, variance_norm_factor_o, start_o, busy_o, result_o, result_val_o.
  - State: IDLE.
- All outputs are registered.
- II writes appear one cycle after the pixel accept.
- Gaps in pix_val_i stall LOAD without affecting results.
- Latency from win_start_i to the first CLEAR write: 1 cycle.
- Latency from the last pixel accept to start_o, macro defined: 1 (final write) + 20 (SQRT) + 1 = 22 cycles. start_o never precedes the final II write.
- The last II write is at address L·L−1 (440).
- result_val_o follows done_i by exactly 1 cycle.
- busy_o falls in the same cycle result_val_o is high.

## Configuration
- **IIW_VARIANCE_EN defined:**
  - sum/sqsum accumulators and the SQRT state are present.
  - variance_norm_factor_o is computed as above.
- **IIW_VARIANCE_EN undefined:**
  - Accumulators and isqrt are removed; LOAD goes directly to START.
  - variance_norm_factor_o is constant 1.
  - Last accept to start_o is 2 cycles.

## Test plan
- All pixels = 1, no gaps:
  - 41 zero writes, then 400 writes with ii[(r)·21+c] = r·c; ii[440] = 400.
  - variance_norm_factor_o = 0.
  - start_o 22 cycles after the last accept.
- Checkerboard 0/255 (p = 255 when (x+y) odd):
  - sum = 51000, sqsum = 13005000, d = 2601000000.
  - variance_norm_factor_o = 51000; ii[440] = 51000.
- Same stream with pix_val_i low for a random 0–3 cycles between pixels: II contents and factor are identical to the no-gap run.
- done_i = 1 with result_i = 1 while in WAIT:
  - result_val_o = 1 and result_o = 1 the next cycle; busy_o = 0.
  - A second done_i in IDLE produces no strobe.
- rst_i asserted after 150 pixels:
  - All outputs 0 next cycle; no start_o.
  - A new win_start_i with an all-ones window reproduces scenario 1 exactly.
- Build without IIW_VARIANCE_EN, all-ones window: variance_norm_factor_o = 1; start_o 2 cycles after the last accept.
